axi_s_drop_sched: RTL

- Packet-boundary scheduler that drives the `dropn` control of the 64-bit AXI-stream inline dropper.
- Passively monitors the dropper's slave-side handshake (tvalid/tready/tlast).
- Decides per packet whether to pass or drop, according to a configured policy (pass, drop-all, drop every Nth, one-shot burst of K).
- Changes `dropn` only where doing so cannot truncate a packet or withdraw an asserted downstream tvalid.

---
 rtl/axi_s_drop_pkg.sv | 14 +
 rtl/axi_s_drop_stats.sv | 36 +++
 rtl/axi_s_drop_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/axi_s_drop_pkg.sv
// Shared definitions for the AXI-stream dropper scheduler: policy mode codes
// and packet-tracking FSM state encoding.
package axi_s_drop_pkg;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_DROP_ALL = 2'd1;
  localparam logic [1:0] MODE_DROP_NTH = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage

// File: rtl/axi_s_drop_stats.sv
// Saturating pass/drop packet counters with synchronous clear, used by
// axi_s_drop_sched when AXI_S_DROP_SCHED_STATS_EN is defined.
module axi_s_drop_stats
  import axi_s_drop_pkg::*;
#(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc_pass,
  input  logic              inc_drop,
  output logic [STAT_W-1:0] stat_pkt_pass,
  output logic [STAT_W-1:0] stat_pkt_drop
);

  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkt_pass <= '0;
      stat_pkt_drop <= '0;
    end else if (clear) begin
      stat_pkt_pass <= '0;
      stat_pkt_drop <= '0;
    end else begin
      if (inc_pass) stat_pkt_pass <= sat_inc(stat_pkt_pass);
      if (inc_drop) stat_pkt_drop <= sat_inc(stat_pkt_drop);
    end
  end

endmodule

// File: rtl/axi_s_drop_sched.sv
// Packet-boundary scheduler driving dropn of the inline AXI-stream dropper.
// Statistics counters are built only when AXI_S_DROP_SCHED_STATS_EN is defined.
module axi_s_drop_sched
  import axi_s_drop_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_n,
  input  logic [CNT_W-1:0]  cfg_burst_len,
  input  logic              burst_start,
  input  logic              ctrl_clear,
  output logic              dropn,
  output logic              in_pkt,
  output logic              burst_active,
  output logic [STAT_W-1:0] stat_pkt_pass,
  output logic [STAT_W-1:0] stat_pkt_drop
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pkt_idx_q, pkt_idx_d;
  logic [CNT_W-1:0] burst_rem_q, burst_rem_d;
  logic [CNT_W-1:0] n_last;
  logic             dropn_q;
  logic             hs, start_beat, end_beat, decide, next_drop;

  assign hs         = mon_tvalid & mon_tready;
  assign start_beat = hs & (state_q == IDLE);
  assign end_beat   = hs & mon_tlast;
  assign decide     = end_beat | ((state_q == IDLE) & ~mon_tvalid);
  assign n_last     = cfg_n - CNT_ONE;

  // The decision looks at counters as they stand after this cycle's commit,
  // so a single-beat packet's own commit is seen by the decision it ends.
  always_comb begin
    state_d     = state_q;
    pkt_idx_d   = pkt_idx_q;
    burst_rem_d = burst_rem_q;
    case (state_q)
      IDLE:    if (start_beat && !mon_tlast) state_d = IN_PKT;
      IN_PKT:  if (end_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_beat) begin
      if (!dropn_q && burst_rem_q != '0) burst_rem_d = burst_rem_q - CNT_ONE;
      if (cfg_mode == MODE_DROP_NTH)
        pkt_idx_d = (pkt_idx_q >= n_last) ? '0 : pkt_idx_q + CNT_ONE;
    end
    if (burst_start && cfg_burst_len != '0) burst_rem_d = cfg_burst_len;
    if (ctrl_clear) pkt_idx_d = '0;
    next_drop = (burst_rem_d != '0) || (cfg_mode == MODE_DROP_ALL) ||
                ((cfg_mode == MODE_DROP_NTH) && (cfg_n != '0) && (pkt_idx_d == n_last));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pkt_idx_q   <= '0;
      burst_rem_q <= '0;
      dropn_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pkt_idx_q   <= pkt_idx_d;
      burst_rem_q <= burst_rem_d;
      if (decide) dropn_q <= ~next_drop;
    end
  end

  assign dropn        = dropn_q;
  assign in_pkt       = (state_q == IN_PKT);
  assign burst_active = (burst_rem_q != '0);

`ifdef AXI_S_DROP_SCHED_STATS_EN
  axi_s_drop_stats #(.STAT_W(STAT_W)) u_stats (
    .clk           (clk),
    .rst           (rst),
    .clear         (ctrl_clear),
    .inc_pass      (start_beat & dropn_q),
    .inc_drop      (start_beat & ~dropn_q),
    .stat_pkt_pass (stat_pkt_pass),
    .stat_pkt_drop (stat_pkt_drop)
  );
`else
  assign stat_pkt_pass = '0;
  assign stat_pkt_drop = '0;
`endif

endmodule
